gf2m_sqr_reduce: RTL and testbench



---
 rtl/gf2m_pkg.sv | 28 ++
 rtl/gf2m_fold_slice.sv | 39 +++
 rtl/gf2m_sqr_reduce.sv | 106 ++++++++++
 tb/tb_gf2m_sqr_reduce.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/gf2m_pkg.sv
// Shared constants and types for the GF(2^M) squaring/reduction datapath.
package gf2m_pkg;

    localparam int          GF_M     = 113;
    localparam int          GF_W     = 16;
    localparam logic [127:0] GF_F_LOW = 128'h201;
    localparam int          GF_NFOLD = (GF_M - 1 + GF_W - 1) / GF_W;

    typedef logic [127:0] elem_t;
    typedef logic [255:0] sqr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FOLD = 2'd1,
        DONE = 2'd2
    } state_t;

    // Degree of a polynomial given as a bit vector; -1 for the zero polynomial.
    function automatic int poly_deg(input logic [127:0] p);
        int d;
        d = -1;
        for (int i = 0; i < 128; i++) begin
            if (p[i]) d = i;
        end
        return d;
    endfunction

endpackage

// File: rtl/gf2m_fold_slice.sv
// Combinational fold of one W-bit chunk of the working register into the bits below it.
module gf2m_fold_slice
    import gf2m_pkg::*;
#(
    parameter int           M     = GF_M,
    parameter int           W     = GF_W,
    parameter logic [127:0] F_LOW = GF_F_LOW,
    parameter int           NFOLD = GF_NFOLD,
    parameter int           CW    = 3
) (
    input  sqr_t            i_r,
    input  logic [CW-1:0]   i_j,
    output sqr_t            o_r
);

    localparam sqr_t FLOW_EXT = {128'b0, F_LOW};

    sqr_t w_r;

    // Landing bits sit strictly below the chunk, so chunk bits are read from i_r.
    always_comb begin
        w_r = i_r;
        for (int jj = 0; jj < NFOLD; jj++) begin
            if (i_j == CW'(jj)) begin
                for (int k = 0; k < W; k++) begin
                    if (M + jj * W + k <= 2 * M - 2) begin
                        if (i_r[M + jj * W + k]) begin
                            w_r[M + jj * W + k] = 1'b0;
                            w_r = w_r ^ (FLOW_EXT << (jj * W + k));
                        end
                    end
                end
            end
        end
    end

    assign o_r = w_r;

endmodule

// File: rtl/gf2m_sqr_reduce.sv
// Sequential modular reduction of a 256-bit unreduced square, W bits folded per clock,
// fixed NFOLD-cycle latency regardless of operand value.
module gf2m_sqr_reduce
    import gf2m_pkg::*;
#(
    parameter int           M     = GF_M,
    parameter int           W     = GF_W,
    parameter logic [127:0] F_LOW = GF_F_LOW
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [255:0] i_in_data,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [127:0] o_out_data,
    output logic         o_busy
);

    localparam int   NFOLD    = (M - 1 + W - 1) / W;
    localparam int   CW       = (NFOLD > 1) ? $clog2(NFOLD) : 1;
    localparam sqr_t IN_MASK  = (sqr_t'(1) << (2 * M - 1)) - sqr_t'(1);
    localparam elem_t OUT_MASK = (elem_t'(1) << M) - elem_t'(1);

    // New bits from a fold must land below the chunk being folded.
    if (poly_deg(F_LOW) > M - W) begin : g_bad_f_low
        $error("gf2m_sqr_reduce: deg(F_LOW) must not exceed M-W");
    end

    state_t          r_state;
    sqr_t            r_work;
    logic [CW-1:0]   r_cnt;
    logic            r_in_ready;
    logic            r_out_valid;
    elem_t           r_out_data;
    logic            r_busy;
    sqr_t            w_fold;

    gf2m_fold_slice #(
        .M     (M),
        .W     (W),
        .F_LOW (F_LOW),
        .NFOLD (NFOLD),
        .CW    (CW)
    ) u_fold (
        .i_r (r_work),
        .i_j (r_cnt),
        .o_r (w_fold)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_work      <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b1;
                    if (i_in_valid && r_in_ready) begin
                        r_work     <= i_in_data & IN_MASK;
                        r_cnt      <= CW'(NFOLD - 1);
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= FOLD;
                    end
                end
                FOLD: begin
                    r_work <= w_fold;
                    if (r_cnt == '0) begin
                        r_out_data  <= w_fold[127:0] & OUT_MASK;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                DONE: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_gf2m_sqr_reduce.sv
// Directed self-checking bench for gf2m_sqr_reduce (M=113, W=16, f = x^113+x^9+1).
module tb_gf2m_sqr_reduce;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    int n_tests;
    int n_fail;

    gf2m_sqr_reduce dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_data   (in_data),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] EXP_X224 = 128'h0000_8000_0000_0000_0000_0000_0001_0080;

    // Presents d, returns cycles from acceptance edge until out_valid is seen (at negedge).
    task automatic send_wait(input logic [255:0] d, output int lat, output logic ok);
        int guard;
        ok = 1'b1;
        lat = 0;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            ok = 1'b0;
            return;
        end
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!out_valid) ok = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: in_ready=%b out_valid=%b busy=%b out_data=%h, required 0 0 0 0",
                     in_ready, out_valid, busy, out_data);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: in_ready=%b busy=%b, required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_vector(input string name, input logic [255:0] d, input logic [127:0] exp);
        int   lat;
        logic ok;
        send_wait(d, lat, ok);
        n_tests++;
        if (!ok || lat !== 7) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d cycles (ok=%b), required 7", name, lat, ok);
        end
        n_tests++;
        if (out_data !== exp) begin
            n_fail++;
            $display("FAIL %s_data: got %h, required %h", name, out_data, exp);
        end
        consume();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_release: out_valid=%b in_ready=%b, required 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int           lat;
        logic         ok;
        logic [255:0] d;
        int           bad_hold;
        d = '0;
        d[113] = 1'b1;
        send_wait(d, lat, ok);
        n_tests++;
        if (!ok || out_data !== 128'h201) begin
            n_fail++;
            $display("FAIL b2b_first: got %h (ok=%b), required %h", out_data, ok, 128'h201);
        end
        // Hold the result for 5 cycles while upstream offers new data.
        bad_hold = 0;
        in_valid = 1'b1;
        in_data  = 256'h1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_data !== 128'h201 || in_ready !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1)
                bad_hold++;
        end
        in_valid = 1'b0;
        in_data  = '0;
        n_tests++;
        if (bad_hold != 0) begin
            n_fail++;
            $display("FAIL b2b_hold: %0d unstable cycles, required 0", bad_hold);
        end
        consume();
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
        // out_ready held high throughout FOLD must not finish the operation early.
        out_ready = 1'b1;
        d = '0;
        d[224] = 1'b1;
        send_wait(d, lat, ok);
        n_tests++;
        if (!ok || lat !== 7 || out_data !== EXP_X224) begin
            n_fail++;
            $display("FAIL b2b_second: got %h lat=%0d ok=%b, required %h lat=7", out_data, lat, ok, EXP_X224);
        end
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_abort();
        int           guard;
        int           lat;
        logic         ok;
        logic [255:0] d;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        d = '0;
        d[224] = 1'b1;
        d[200] = 1'b1;
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
        n_tests++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_started: busy=%b in_ready=%b, required 1 0", busy, in_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 128'h0) begin
            n_fail++;
            $display("FAIL abort_reset: in_ready=%b out_valid=%b busy=%b out_data=%h, required 0 0 0 0",
                     in_ready, out_valid, busy, out_data);
        end
        @(negedge clk);
        rst = 1'b0;
        d = '0;
        d[113] = 1'b1;
        send_wait(d, lat, ok);
        n_tests++;
        if (!ok || lat !== 7 || out_data !== 128'h201) begin
            n_fail++;
            $display("FAIL abort_recover: got %h lat=%0d ok=%b, required %h lat=7", out_data, lat, ok, 128'h201);
        end
        consume();
    endtask

    initial begin
        logic [255:0] v;
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        test_reset();
        test_vector("one", 256'h1, 128'h1);
        v = '0; v[113] = 1'b1;
        test_vector("x113", v, 128'h201);
        v = '0; v[224] = 1'b1;
        test_vector("x224", v, EXP_X224);
        v = '0; v[255] = 1'b1; v[0] = 1'b1;
        test_vector("mask255", v, 128'h1);
        test_back_to_back();
        test_abort();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
